// File: rtl/regbank_write_ctrl.sv
// Register bank write-port controller.
// After reset it sweeps every register to zero, then arbitrates the single write port between
// the writeback stage (priority) and the debug/loader unit (with a starvation guard). All bank
// write signals are registered, one cycle after the accepting handshake.
module regbank_write_ctrl #(
    parameter int unsigned ADDR_BITS    = 5,
    parameter int unsigned DATA_BITS    = 32,
    parameter int unsigned STARVE_LIMIT = 4,
    parameter bit          LOCK_R0      = 1'b1
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_wb_valid,
    input  logic [ADDR_BITS-1:0]      i_wb_addr,
    input  logic [DATA_BITS-1:0]      i_wb_data,
    output logic                      o_wb_ready,
    input  logic                      i_dbg_valid,
    input  logic [ADDR_BITS-1:0]      i_dbg_addr,
    input  logic [DATA_BITS-1:0]      i_dbg_data,
    output logic                      o_dbg_ready,
    output logic                      o_init_busy,
    output logic                      o_rf_we,
    output logic [ADDR_BITS-1:0]      o_rf_addr,
    output logic [DATA_BITS-1:0]      o_rf_data,
    output logic [(2**ADDR_BITS)-1:0] o_rf_we_onehot
);

    localparam int unsigned NUM_REGS    = 2 ** ADDR_BITS;
    localparam int unsigned STARVE_BITS = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [STARVE_BITS-1:0] STARVE_MAX = STARVE_BITS'(STARVE_LIMIT);

    typedef enum logic [0:0] {StInit, StRun} state_e;

    state_e                 r_state;
    logic [ADDR_BITS-1:0]   r_init_cnt;
    logic [STARVE_BITS-1:0] r_starve_cnt;
    logic                   r_init_busy;
    logic                   r_rf_we;
    logic [ADDR_BITS-1:0]   r_rf_addr;
    logic [DATA_BITS-1:0]   r_rf_data;
    logic [NUM_REGS-1:0]    r_rf_we_onehot;

    logic                   w_run;
    logic                   w_force_dbg;
    logic                   w_wb_ready;
    logic                   w_dbg_ready;
    logic                   w_wb_xfer;
    logic                   w_dbg_xfer;
    logic                   w_xfer;
    logic [ADDR_BITS-1:0]   w_xfer_addr;
    logic [DATA_BITS-1:0]   w_xfer_data;
    logic                   w_xfer_we;
    logic [NUM_REGS-1:0]    w_xfer_onehot;
    logic [NUM_REGS-1:0]    w_init_onehot;

    // Arbitration: WB first unless debug has waited out its starvation budget.
    always_comb begin
        // Nothing is accepted while reset is asserted, so no request is lost to a reset.
        w_run         = (r_state == StRun) && !i_rst;
        w_force_dbg   = i_dbg_valid && (r_starve_cnt == STARVE_MAX);
        w_wb_ready    = w_run && !w_force_dbg;
        w_dbg_ready   = w_run && (!i_wb_valid || w_force_dbg);
        w_wb_xfer     = i_wb_valid && w_wb_ready;
        w_dbg_xfer    = i_dbg_valid && w_dbg_ready;
        w_xfer        = w_wb_xfer || w_dbg_xfer;
        w_xfer_addr   = w_wb_xfer ? i_wb_addr : i_dbg_addr;
        w_xfer_data   = w_wb_xfer ? i_wb_data : i_dbg_data;
        // A write to r0 still completes its handshake but never strobes the bank.
        w_xfer_we     = w_xfer && !(LOCK_R0 && (w_xfer_addr == '0));
        w_xfer_onehot = w_xfer_we ? ({{(NUM_REGS-1){1'b0}}, 1'b1} << w_xfer_addr) : '0;
        w_init_onehot = {{(NUM_REGS-1){1'b0}}, 1'b1} << r_init_cnt;
    end

    // Control FSM with registered bank write outputs and starvation counter.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state        <= StInit;
            r_init_cnt     <= '0;
            r_starve_cnt   <= '0;
            r_init_busy    <= 1'b1;
            r_rf_we        <= 1'b0;
            r_rf_addr      <= '0;
            r_rf_data      <= '0;
            r_rf_we_onehot <= '0;
        end else begin
            case (r_state)
                StInit: begin
                    // The sweep writes r0 too, regardless of LOCK_R0.
                    r_rf_we        <= 1'b1;
                    r_rf_addr      <= r_init_cnt;
                    r_rf_data      <= '0;
                    r_rf_we_onehot <= w_init_onehot;
                    r_init_cnt     <= r_init_cnt + 1'b1;
                    if (&r_init_cnt) begin
                        r_state     <= StRun;
                        r_init_busy <= 1'b0;
                    end
                end
                StRun: begin
                    r_rf_we        <= w_xfer_we;
                    r_rf_we_onehot <= w_xfer_onehot;
                    if (w_xfer) begin
                        r_rf_addr <= w_xfer_addr;
                        r_rf_data <= w_xfer_data;
                    end
                    if (w_dbg_xfer || !i_dbg_valid) begin
                        r_starve_cnt <= '0;
                    end else if (w_wb_xfer && (r_starve_cnt != STARVE_MAX)) begin
                        r_starve_cnt <= r_starve_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= StInit;
                end
            endcase
        end
    end

    // Output mapping.
    always_comb begin
        o_wb_ready     = w_wb_ready;
        o_dbg_ready    = w_dbg_ready;
        o_init_busy    = r_init_busy;
        o_rf_we        = r_rf_we;
        o_rf_addr      = r_rf_addr;
        o_rf_data      = r_rf_data;
        o_rf_we_onehot = r_rf_we_onehot;
    end

endmodule

// File: tb/tb_regbank_write_ctrl.sv
// Self-checking bench for regbank_write_ctrl: directed literal checks plus randomized traffic
// compared every cycle against a behavioural model of the write port and the register bank.
module tb_regbank_write_ctrl;

    localparam int AW = 5;
    localparam int DW = 32;
    localparam int NR = 32;
    localparam int SL = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          wb_valid, dbg_valid;
    logic [AW-1:0] wb_addr, dbg_addr;
    logic [DW-1:0] wb_data, dbg_data;
    logic          wb_ready, dbg_ready, init_busy, rf_we;
    logic [AW-1:0] rf_addr;
    logic [DW-1:0] rf_data;
    logic [NR-1:0] rf_we_onehot;

    int n_tests = 0;
    int n_fail  = 0;

    regbank_write_ctrl #(
        .ADDR_BITS(AW), .DATA_BITS(DW), .STARVE_LIMIT(SL), .LOCK_R0(1'b1)
    ) u_dut (
        .i_clk(clk), .i_rst(rst),
        .i_wb_valid(wb_valid), .i_wb_addr(wb_addr), .i_wb_data(wb_data), .o_wb_ready(wb_ready),
        .i_dbg_valid(dbg_valid), .i_dbg_addr(dbg_addr), .i_dbg_data(dbg_data),
        .o_dbg_ready(dbg_ready), .o_init_busy(init_busy), .o_rf_we(rf_we),
        .o_rf_addr(rf_addr), .o_rf_data(rf_data), .o_rf_we_onehot(rf_we_onehot)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- behavioural model ----------------
    // The port is "busy sweeping" for NR writes after reset; afterwards each cycle one requester
    // may own the port, and the bank contents follow the committed writes.
    logic          m_known = 1'b0;
    int            m_init_left = 0;
    int            m_starve = 0;   // WB grants in a row while debug was waiting
    logic          m_wb_xfer = 1'b0, m_dbg_xfer = 1'b0;
    logic          exp_we, exp_busy;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_data;
    logic [NR-1:0] exp_oh;
    logic [DW-1:0] m_bank [NR];
    logic [DW-1:0] dut_bank [NR];

    initial begin
        for (int i = 0; i < NR; i++) begin
            m_bank[i]   = '0;
            dut_bank[i] = '0;
        end
    end

    always @(negedge clk) begin : compare
        logic          run, forced, give_wb, give_dbg, off_wb, off_dbg;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        int            idx;
        run      = !rst && (m_init_left == 0);
        forced   = dbg_valid && (m_starve >= SL);
        give_wb  = run && wb_valid && !forced;
        give_dbg = run && dbg_valid && !give_wb;
        // What each side would be offered if it asked this cycle.
        off_wb   = run && !forced;
        off_dbg  = run && (!wb_valid || forced);
        if (m_known) begin
            chk("wb_ready", wb_ready, off_wb);
            chk("dbg_ready", dbg_ready, off_dbg);
            chk("init_busy", init_busy, exp_busy);
            chk("rf_we", rf_we, exp_we);
            chk("rf_addr", rf_addr, exp_addr);
            chk("rf_data", rf_data, exp_data);
            chk("rf_we_onehot", rf_we_onehot, exp_oh);
            if (rf_we === 1'b1) dut_bank[rf_addr] = rf_data;
        end
        m_wb_xfer  = give_wb;
        m_dbg_xfer = give_dbg;
        if (rst) begin
            m_known     = 1'b1;
            m_init_left = NR;
            m_starve    = 0;
            exp_we = 1'b0; exp_addr = '0; exp_data = '0; exp_oh = '0; exp_busy = 1'b1;
        end else if (m_init_left > 0) begin
            idx = NR - m_init_left;
            exp_we   = 1'b1;
            exp_addr = AW'(idx);
            exp_data = '0;
            exp_oh   = NR'(1) << idx;
            m_bank[idx] = '0;
            m_init_left--;
            exp_busy = (m_init_left != 0);
        end else begin
            exp_we = 1'b0;
            exp_oh = '0;
            if (give_wb || give_dbg) begin
                a = give_wb ? wb_addr : dbg_addr;
                d = give_wb ? wb_data : dbg_data;
                exp_addr = a;
                exp_data = d;
                if (a != 0) begin
                    exp_we    = 1'b1;
                    exp_oh    = NR'(1) << a;
                    m_bank[a] = d;
                end
            end
            if (give_wb && dbg_valid) m_starve = (m_starve < SL) ? m_starve + 1 : SL;
            else if (!dbg_valid || give_dbg) m_starve = 0;
        end
    end

    // ---------------- stimulus and literal checks ----------------
    initial begin
        int busy_cnt;
        int n;
        rst = 1'b1; wb_valid = 1'b0; dbg_valid = 1'b0;
        wb_addr = '0; dbg_addr = '0; wb_data = '0; dbg_data = '0;
        repeat (3) step();
        rst = 1'b0;

        // Init sweep: 32 busy cycles, addresses 0..31 in order, no readies.
        busy_cnt = 0;
        @(negedge clk);
        chk("init_wb_ready", wb_ready, 0);
        chk("init_dbg_ready", dbg_ready, 0);
        if (init_busy === 1'b1) busy_cnt++;
        for (int k = 0; k < NR; k++) begin
            step();
            @(negedge clk);
            chk("sweep_we", rf_we, 1);
            chk("sweep_addr", rf_addr, k);
            chk("sweep_data", rf_data, 0);
            chk("sweep_onehot", rf_we_onehot, 64'(32'h1 << k));
            if (init_busy === 1'b1) busy_cnt++;
        end
        chk("init_busy_cycles", busy_cnt, 32);
        chk("init_done", init_busy, 0);

        // Single WB write.
        step();
        wb_valid = 1'b1; wb_addr = 5'd7; wb_data = 32'hDEADBEEF;
        @(negedge clk);
        chk("wb7_ready", wb_ready, 1);
        step();
        wb_valid = 1'b0;
        @(negedge clk);
        chk("wb7_we", rf_we, 1);
        chk("wb7_addr", rf_addr, 7);
        chk("wb7_data", rf_data, 32'hDEADBEEF);
        chk("wb7_onehot", rf_we_onehot, 32'h80);
        step();
        @(negedge clk);
        chk("wb7_idle_we", rf_we, 0);

        // Both requesting continuously: 4 WB grants then one forced debug grant.
        step();
        wb_valid = 1'b1; wb_addr = 5'd3; wb_data = 32'h33;
        dbg_valid = 1'b1; dbg_addr = 5'd9; dbg_data = 32'h99;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            chk("starve_wb_ready", wb_ready, (i % 5) != 4);
            chk("starve_dbg_ready", dbg_ready, (i % 5) == 4);
            step();
        end
        wb_valid = 1'b0; dbg_valid = 1'b0;

        // Debug write to locked r0.
        step();
        dbg_valid = 1'b1; dbg_addr = 5'd0; dbg_data = 32'h1234;
        @(negedge clk);
        chk("r0_dbg_ready", dbg_ready, 1);
        step();
        dbg_valid = 1'b0;
        @(negedge clk);
        chk("r0_we", rf_we, 0);
        chk("r0_onehot", rf_we_onehot, 0);
        chk("r0_addr", rf_addr, 0);
        chk("r0_data", rf_data, 32'h1234);

        // Reset pulse while WB addr 5 is presented.
        step();
        rst = 1'b1; wb_valid = 1'b1; wb_addr = 5'd5; wb_data = 32'h5555;
        @(negedge clk);
        step();
        rst = 1'b0; wb_valid = 1'b0;
        @(negedge clk);
        chk("rst5_we", rf_we, 0);
        chk("rst5_onehot", rf_we_onehot, 0);
        chk("rst5_busy", init_busy, 1);
        step();
        @(negedge clk);
        chk("resweep_we", rf_we, 1);
        chk("resweep_addr", rf_addr, 0);
        chk("resweep_busy", init_busy, 1);
        n = 0;
        while (init_busy === 1'b1 && n < 40) begin
            step();
            @(negedge clk);
            n++;
        end
        chk("resweep_len", n, 31);

        // Debug alone to r31.
        step();
        dbg_valid = 1'b1; dbg_addr = 5'd31; dbg_data = 32'hFFFFFFFF;
        @(negedge clk);
        chk("d31_ready", dbg_ready, 1);
        step();
        dbg_valid = 1'b0;
        @(negedge clk);
        chk("d31_we", rf_we, 1);
        chk("d31_onehot", rf_we_onehot, 32'h80000000);
        chk("d31_data", rf_data, 32'hFFFFFFFF);

        // Random traffic; requesters hold until the model says they were accepted.
        for (int c = 0; c < 3000; c++) begin
            step();
            if (!(wb_valid && !m_wb_xfer)) begin
                wb_valid = ($urandom_range(0, 2) != 0);
                wb_addr  = $urandom_range(0, 1) ? AW'($urandom_range(0, 3))
                                                : AW'($urandom_range(0, NR - 1));
                wb_data  = $urandom;
            end
            if (!(dbg_valid && !m_dbg_xfer)) begin
                dbg_valid = ($urandom_range(0, 2) == 0);
                dbg_addr  = $urandom_range(0, 1) ? AW'($urandom_range(0, 3))
                                                 : AW'($urandom_range(0, NR - 1));
                dbg_data  = $urandom;
            end
            rst = ($urandom_range(0, 299) == 0);
        end
        step();
        rst = 1'b0; wb_valid = 1'b0; dbg_valid = 1'b0;
        // Long enough for any sweep in progress to finish and the last write to land.
        repeat (40) step();
        @(negedge clk);
        for (int i = 0; i < NR; i++) chk("bank_contents", dut_bank[i], m_bank[i]);
        chk("bank_r0_zero", dut_bank[0], 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
